// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one load/store per instruction over req/gnt/rvalid, load alignment/extension, registered write-back.
// Optional MEM_MISALIGN_CHECK_EN: misaligned half/word accesses are dropped and flagged on misalign_o.
module mem_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ex_valid_i,
  output logic                      ex_ready_o,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result_i,
  input  logic [DATA_WIDTH-1:0]     ex_store_data_i,
  input  logic [1:0]                ex_mem_op_i,
  input  logic [1:0]                ex_mem_size_i,
  input  logic                      ex_mem_unsigned_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
  input  logic                      ex_rd_we_i,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  output logic [ADDR_WIDTH-1:0]     data_addr_o,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  input  logic                      data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  output logic                      wb_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_o,
  output logic                      wb_we_o,
  output logic [DATA_WIDTH-1:0]     wb_data_o,
  output logic                      misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                off_q;
  logic [1:0]                size_q;
  logic                      uns_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      rd_we_q;

  logic                      is_mem;
  logic                      misaligned;
  logic [1:0]                in_off;
  logic [3:0]                be_in;
  logic [DATA_WIDTH-1:0]     wdata_in;
  logic [DATA_WIDTH-1:0]     shifted;
  logic [DATA_WIDTH-1:0]     load_data;

  assign is_mem = (ex_mem_op_i == 2'd1) || (ex_mem_op_i == 2'd2);

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = is_mem &&
                      (((ex_mem_size_i == 2'd1) && ex_alu_result_i[0]) ||
                       (ex_mem_size_i[1] && (ex_alu_result_i[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Lane offset: halves use addr[1] only, words always start at lane 0.
  always_comb begin
    in_off   = 2'b00;
    be_in    = 4'b1111;
    wdata_in = ex_store_data_i;
    case (ex_mem_size_i)
      2'd0: begin
        in_off   = ex_alu_result_i[1:0];
        be_in    = 4'b0001 << ex_alu_result_i[1:0];
        wdata_in = {4{ex_store_data_i[7:0]}};
      end
      2'd1: begin
        in_off   = {ex_alu_result_i[1], 1'b0};
        be_in    = 4'b0011 << {ex_alu_result_i[1], 1'b0};
        wdata_in = {2{ex_store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = data_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_data = data_rdata_i;
    case (size_q)
      2'd0: load_data = {{(DATA_WIDTH-8){shifted[7] & ~uns_q}}, shifted[7:0]};
      2'd1: load_data = {{(DATA_WIDTH-16){shifted[15] & ~uns_q}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ex_valid_i && is_mem && !misaligned) state_d = REQ;
      REQ:  if (data_gnt_i) state_d = data_we_o ? IDLE : RESP;
      RESP: if (data_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ex_ready_o = (state_q == IDLE);
    data_req_o = (state_q == REQ);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_we_o      <= 1'b0;
      wb_data_o    <= '0;
      misalign_o   <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      case (state_q)
        IDLE: if (ex_valid_i) begin
          if (!is_mem) begin
            wb_valid_o <= 1'b1;
            wb_data_o  <= ex_alu_result_i;
            wb_rd_o    <= ex_rd_i;
            wb_we_o    <= ex_rd_we_i;
          end else if (misaligned) begin
            wb_valid_o <= 1'b1;
            wb_rd_o    <= ex_rd_i;
            wb_we_o    <= 1'b0;
            misalign_o <= 1'b1;
          end else begin
            data_addr_o  <= {ex_alu_result_i[ADDR_WIDTH-1:2], 2'b00};
            data_we_o    <= (ex_mem_op_i == 2'd2);
            data_be_o    <= be_in;
            data_wdata_o <= wdata_in;
            off_q        <= in_off;
            size_q       <= ex_mem_size_i;
            uns_q        <= ex_mem_unsigned_i;
            rd_q         <= ex_rd_i;
            rd_we_q      <= ex_rd_we_i;
          end
        end
        REQ: if (data_gnt_i && data_we_o) begin
          wb_valid_o <= 1'b1;
          wb_rd_o    <= rd_q;
          wb_we_o    <= 1'b0;
        end
        RESP: if (data_rvalid_i) begin
          wb_valid_o <= 1'b1;
          wb_rd_o    <= rd_q;
          wb_we_o    <= rd_we_q;
          wb_data_o  <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected write-backs and memory transactions; monitor and memory responder check.
module tb_mem_stage;

`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [31:0] ex_alu_result_i = '0;
  logic [31:0] ex_store_data_i = '0;
  logic [1:0]  ex_mem_op_i = '0;
  logic [1:0]  ex_mem_size_i = '0;
  logic        ex_mem_unsigned_i = 1'b0;
  logic [4:0]  ex_rd_i = '0;
  logic        ex_rd_we_i = 1'b0;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_alu_result_i(ex_alu_result_i), .ex_store_data_i(ex_store_data_i),
    .ex_mem_op_i(ex_mem_op_i), .ex_mem_size_i(ex_mem_size_i),
    .ex_mem_unsigned_i(ex_mem_unsigned_i), .ex_rd_i(ex_rd_i), .ex_rd_we_i(ex_rd_we_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o),
    .wb_data_o(wb_data_o), .misalign_o(misalign_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    bit          chk_data;
    bit          chk_rd;
    bit          mis;
  } wb_t;

  typedef struct {
    bit          ld;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned gd;
    int unsigned rv;
  } mem_t;

  wb_t  exp_q[$];
  mem_t mem_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mem_auto = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic bit ref_misal(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd1) return (a % 2) != 0;
    if (size >= 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic int unsigned ref_off(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd0) return a % 4;
    if (size == 2'd1) return ((a % 4) / 2) * 2;
    return 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] a);
    int unsigned o = ref_off(size, a);
    if (size == 2'd0) return 4'(1 << o);
    if (size == 2'd1) return 4'(3 << o);
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return (d % 256) * 32'h0101_0101;
    if (size == 2'd1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v = r >> (8 * ref_off(size, a));
    if (size == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (size == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
      return v;
    end
    return r;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input logic we, input logic [31:0] rdata,
                       input int unsigned gd, input int unsigned rv);
    bit   is_mem = (op == 2'd1) || (op == 2'd2);
    bit   mis = MIS && is_mem && ref_misal(size, a);
    int   waited = 0;
    if (!is_mem)
      exp_q.push_back('{rd: rd, we: we, data: a, chk_data: 1, chk_rd: 1, mis: 0});
    else if (mis)
      exp_q.push_back('{rd: rd, we: 1'b0, data: '0, chk_data: 0, chk_rd: 0, mis: 1});
    else if (op == 2'd2) begin
      exp_q.push_back('{rd: rd, we: 1'b0, data: '0, chk_data: 0, chk_rd: 0, mis: 0});
      mem_q.push_back('{ld: 0, addr: a & 32'hFFFF_FFFC, be: ref_be(size, a),
                        wdata: ref_wdata(size, d), rdata: '0, gd: gd, rv: rv});
    end else begin
      exp_q.push_back('{rd: rd, we: we, data: ref_load(size, uns, a, rdata),
                        chk_data: 1, chk_rd: 1, mis: 0});
      mem_q.push_back('{ld: 1, addr: a & 32'hFFFF_FFFC, be: ref_be(size, a),
                        wdata: '0, rdata: rdata, gd: gd, rv: rv});
    end
    ex_valid_i = 1'b1; ex_mem_op_i = op; ex_mem_size_i = size; ex_mem_unsigned_i = uns;
    ex_alu_result_i = a; ex_store_data_i = d; ex_rd_i = rd; ex_rd_we_i = we;
    while (!ex_ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ex_ready_o) chk("ex_ready_timeout", 32'(ex_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!is_mem || mis) begin
      chk("single_cycle_wb_valid", 32'(wb_valid_o), 32'd1);
      chk("single_cycle_ex_ready", 32'(ex_ready_o), 32'd1);
    end
    ex_valid_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every write-back pulse.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (wb_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wb_valid", 32'(wb_valid_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_we", 32'(wb_we_o), 32'(e.we));
          chk("misalign", 32'(misalign_o), 32'(e.mis));
          if (e.chk_rd) chk("wb_rd", 32'(wb_rd_o), 32'(e.rd));
          if (e.chk_data) chk("wb_data", wb_data_o, e.data);
        end
      end
    end
  end

  // Memory responder: checks request fields stay stable until grant, then returns load data.
  initial begin
    mem_t m;
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        if (data_req_o) begin
          if (mem_q.size() == 0) begin
            chk("unexpected_data_req", 32'(data_req_o), 32'd0);
            data_gnt_i = 1'b1;
            @(negedge clk);
            data_gnt_i = 1'b0;
          end else begin
            m = mem_q.pop_front();
            data_gnt_i = 1'b0;
            for (int unsigned k = 0; k <= m.gd; k++) begin
              chk("req_held", 32'(data_req_o), 32'd1);
              chk("data_addr", data_addr_o, m.addr);
              chk("data_we", 32'(data_we_o), 32'(!m.ld));
              chk("data_be", 32'(data_be_o), 32'(m.be));
              if (!m.ld) chk("data_wdata", data_wdata_o, m.wdata);
              chk("ex_ready_busy", 32'(ex_ready_o), 32'd0);
              data_rvalid_i = ($urandom % 2) == 0;
              data_rdata_i = $urandom;
              if (k == m.gd) data_gnt_i = 1'b1;
              @(negedge clk);
            end
            data_gnt_i = 1'b0;
            data_rvalid_i = 1'b0;
            if (m.ld) begin
              for (int unsigned k = 0; k < m.rv; k++) begin
                chk("resp_req_low", 32'(data_req_o), 32'd0);
                chk("resp_ex_ready", 32'(ex_ready_o), 32'd0);
                @(negedge clk);
              end
              data_rvalid_i = 1'b1;
              data_rdata_i = m.rdata;
              @(negedge clk);
              data_rvalid_i = 1'b0;
              data_rdata_i = $urandom;
            end
          end
        end else begin
          data_gnt_i = ($urandom % 4) == 0;
          data_rvalid_i = ($urandom % 4) == 0;
          data_rdata_i = $urandom;
        end
      end
    end
  end

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_data_req", 32'(data_req_o), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_data_addr", data_addr_o, 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_ex_ready", 32'(ex_ready_o), 32'd1);
    mem_auto = 1'b1;

    issue(2'd0, 2'd2, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 32'h0, 0, 0);
    issue(2'd2, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 5'd1, 1'b0, 32'h0, 2, 0);
    issue(2'd1, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 5'd7, 1'b1, 32'h8001_0000, 0, 0);
    issue(2'd1, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 5'd8, 1'b1, 32'h8001_0000, 1, 1);
    issue(2'd1, 2'd0, 1'b0, 32'h0000_3001, 32'h0, 5'd9, 1'b1, 32'h0000_7F00, 3, 2);
    issue(2'd1, 2'd2, 1'b0, 32'h0000_4002, 32'h0, 5'd10, 1'b1, 32'hCAFE_F00D, 0, 0);
    issue(2'd3, 2'd1, 1'b0, 32'h0000_5005, 32'h0, 5'd11, 1'b1, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++)
      issue(2'd0, 2'd0, 1'b0, $urandom, 32'h0, 5'(i + 12), 1'b1, 32'h0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      issue(2'($urandom % 4), 2'($urandom % 4), 1'($urandom % 2), $urandom, $urandom,
            5'($urandom % 32), 1'($urandom % 2), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom % 3 == 0) @(negedge clk);
    end

    waited = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("memq_drained", 32'(mem_q.size()), 32'd0);

    // Reset mid-load in RESP; the late rvalid must be ignored.
    mem_auto = 1'b0;
    @(negedge clk);
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    ex_valid_i = 1'b1; ex_mem_op_i = 2'd1; ex_mem_size_i = 2'd2;
    ex_alu_result_i = 32'h0000_6000; ex_rd_i = 5'd3; ex_rd_we_i = 1'b1;
    @(negedge clk);
    ex_valid_i = 1'b0;
    chk("rst_test_req", 32'(data_req_o), 32'd1);
    data_gnt_i = 1'b1;
    @(negedge clk);
    data_gnt_i = 1'b0;
    chk("rst_test_in_resp", 32'(ex_ready_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
    @(negedge clk);
    data_rvalid_i = 1'b0;
    chk("rst_test_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_test_ex_ready", 32'(ex_ready_o), 32'd1);
    chk("rst_test_req_low", 32'(data_req_o), 32'd0);
    chk("rst_test_wb_data", wb_data_o, 32'd0);
    chk("rst_test_be", 32'(data_be_o), 32'd0);
    chk("rst_test_addr", data_addr_o, 32'd0);
    issue(2'd0, 2'd0, 1'b0, 32'h0000_00AA, 32'h0, 5'd4, 1'b1, 32'h0, 0, 0);
    repeat (2) @(negedge clk);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
